// File: rtl/uint16_digit_scanner_if.sv
// Bus between the digit scanner and its user / display stage.
// The master side drives the conversion request and the display-stage quotient.
interface uint16_digit_scanner_if;
  logic        start;
  logic [15:0] number;
  logic        ready;
  logic [15:0] stage_number;
  logic [15:0] remaining_number;
  logic [2:0]  digit_index;
  logic        digit_valid;
  logic        done;
  logic [2:0]  digit_count;
  logic        overflow;

  modport master (
    output start, number, remaining_number,
    input  ready, stage_number, digit_index, digit_valid, done, digit_count, overflow
  );

  modport slave (
    input  start, number, remaining_number,
    output ready, stage_number, digit_index, digit_valid, done, digit_count, overflow
  );
endinterface

// File: rtl/uint16_digit_scanner.sv
// Walks a latched 16-bit value one decimal digit at a time, least significant first,
// time-multiplexing a single external display stage that supplies value / 10.
module uint16_digit_scanner #(
  parameter int unsigned MAX_DIGITS  = 5,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  uint16_digit_scanner_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StScan, StFinish} state_e;

  localparam logic [7:0] HoldLast  = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] IndexLast = 3'(MAX_DIGITS - 1);

  state_e      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic [2:0]  index_q, index_d;
  logic [7:0]  hold_q, hold_d;
  logic [2:0]  count_q, count_d;
  logic        overflow_q, overflow_d;

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    index_d    = index_q;
    hold_d     = hold_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          value_d = bus.number;
          index_d = 3'd0;
          hold_d  = 8'd0;
          state_d = StScan;
        end
      end
      StScan: begin
        hold_d = hold_q + 8'd1;
        // The quotient is only trusted on the last hold cycle of each digit.
        if (hold_q == HoldLast) begin
          if (bus.remaining_number == 16'd0) begin
            count_d    = index_q + 3'd1;
            overflow_d = 1'b0;
            state_d    = StFinish;
          end else if (index_q == IndexLast) begin
            count_d    = 3'(MAX_DIGITS);
            overflow_d = 1'b1;
            state_d    = StFinish;
          end else begin
            value_d = bus.remaining_number;
            index_d = index_q + 3'd1;
            hold_d  = 8'd0;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      value_q    <= 16'd0;
      index_q    <= 3'd0;
      hold_q     <= 8'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      index_q    <= index_d;
      hold_q     <= hold_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.ready        = (state_q == StIdle);
  assign bus.digit_valid  = (state_q == StScan);
  assign bus.done         = (state_q == StFinish);
  assign bus.stage_number = value_q;
  assign bus.digit_index  = index_q;
  assign bus.digit_count  = count_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_uint16_digit_scanner.sv
// Scoreboard bench: two scanner instances (hold 1 / max 5 and hold 3 / max 3), each fed by
// a behavioural display stage; per-cycle expected snapshots are queued at acceptance.
module tb_uint16_digit_scanner;

  localparam int HoldA = 1;
  localparam int MaxA  = 5;
  localparam int HoldB = 3;
  localparam int MaxB  = 3;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        ready;
    logic [15:0] stage;
    logic [2:0]  idx;
    logic [2:0]  cnt;
    logic        ovf;
  } snap_t;

  logic clk;
  logic rst_na, rst_nb;
  logic mon_en;
  int   n_checks, n_errors;

  snap_t      qa[$];
  snap_t      qb[$];
  logic [2:0] last_cnt[2];
  logic       last_ovf[2];

  uint16_digit_scanner_if ifa ();
  uint16_digit_scanner_if ifb ();

  // Behavioural display stage: quotient of the presented value.
  assign ifa.remaining_number = ifa.stage_number / 16'd10;
  assign ifb.remaining_number = ifb.stage_number / 16'd10;

  uint16_digit_scanner #(.MAX_DIGITS(MaxA), .HOLD_CYCLES(HoldA)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_na),
    .bus   (ifa)
  );

  uint16_digit_scanner #(.MAX_DIGITS(MaxB), .HOLD_CYCLES(HoldB)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_nb),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? qa.size() : qb.size();
  endfunction

  task automatic push(input int id, input snap_t e);
    if (id == 0) qa.push_back(e);
    else         qb.push_back(e);
  endtask

  function automatic int ndig(input int num, input int maxd);
    int v;
    v = num;
    for (int k = 0; k < maxd; k++) begin
      if (v / 10 == 0) return k + 1;
      v = v / 10;
    end
    return maxd;
  endfunction

  // Expected cycle-by-cycle snapshots from the cycle after acceptance to the ready cycle.
  task automatic gen_stream(input int id, input logic [15:0] num, input int hold,
                            input int maxd);
    snap_t      e;
    logic [15:0] v;
    logic [2:0] cnt;
    logic       ovf;
    v   = num;
    cnt = 3'd0;
    ovf = 1'b0;
    for (int k = 0; k < maxd; k++) begin
      for (int h = 0; h < hold; h++) begin
        e = '{valid: 1'b1, done: 1'b0, ready: 1'b0, stage: v, idx: 3'(k),
              cnt: last_cnt[id], ovf: last_ovf[id]};
        push(id, e);
      end
      if (v / 16'd10 == 16'd0) begin
        cnt = 3'(k + 1);
        break;
      end
      if (k == maxd - 1) begin
        cnt = 3'(maxd);
        ovf = 1'b1;
        break;
      end
      v = v / 16'd10;
    end
    last_cnt[id] = cnt;
    last_ovf[id] = ovf;
    e = '{valid: 1'b0, done: 1'b1, ready: 1'b0, stage: 16'd0, idx: 3'd0, cnt: cnt, ovf: ovf};
    push(id, e);
    e = '{valid: 1'b0, done: 1'b0, ready: 1'b1, stage: 16'd0, idx: 3'd0, cnt: cnt, ovf: ovf};
    push(id, e);
  endtask

  task automatic mon_step(input int id, input snap_t got);
    snap_t e;
    string p;
    p = (id == 0) ? "A" : "B";
    if (qsize(id) == 0) begin
      check({p, " idle valid"}, 32'(got.valid), 32'd0);
      check({p, " idle done"}, 32'(got.done), 32'd0);
    end else begin
      if (id == 0) e = qa.pop_front();
      else         e = qb.pop_front();
      check({p, " valid"}, 32'(got.valid), 32'(e.valid));
      check({p, " done"}, 32'(got.done), 32'(e.done));
      check({p, " ready"}, 32'(got.ready), 32'(e.ready));
      check({p, " digit_count"}, 32'(got.cnt), 32'(e.cnt));
      check({p, " overflow"}, 32'(got.ovf), 32'(e.ovf));
      if (e.valid) begin
        check({p, " stage_number"}, 32'(got.stage), 32'(e.stage));
        check({p, " digit_index"}, 32'(got.idx), 32'(e.idx));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(0, {ifa.digit_valid, ifa.done, ifa.ready, ifa.stage_number, ifa.digit_index,
                   ifa.digit_count, ifa.overflow});
      mon_step(1, {ifb.digit_valid, ifb.done, ifb.ready, ifb.stage_number, ifb.digit_index,
                   ifb.digit_count, ifb.overflow});
    end
  end

  task automatic drain(input int id);
    int n;
    n = 0;
    while (qsize(id) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain timeout", 32'(qsize(id)), 32'd0);
  endtask

  // Single pulsed conversion; start is dropped right after the accepting edge.
  task automatic conv(input int id, input logic [15:0] num);
    @(posedge clk);
    #1;
    if (id == 0) begin ifa.start = 1'b1; ifa.number = num; end
    else         begin ifb.start = 1'b1; ifb.number = num; end
    @(posedge clk);
    #1;
    if (id == 0) ifa.start = 1'b0;
    else         ifb.start = 1'b0;
    if (id == 0) gen_stream(0, num, HoldA, MaxA);
    else         gen_stream(1, num, HoldB, MaxB);
    drain(id);
  endtask

  task automatic check_reset(input string p, input logic rdy, input logic vld, input logic dn,
                             input logic [15:0] stg, input logic [2:0] idx,
                             input logic [2:0] cnt, input logic ovf);
    check({p, " rst ready"}, 32'(rdy), 32'd1);
    check({p, " rst valid"}, 32'(vld), 32'd0);
    check({p, " rst done"}, 32'(dn), 32'd0);
    check({p, " rst stage_number"}, 32'(stg), 32'd0);
    check({p, " rst digit_index"}, 32'(idx), 32'd0);
    check({p, " rst digit_count"}, 32'(cnt), 32'd0);
    check({p, " rst overflow"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    snap_t e;
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    rst_na   = 1'b0;
    rst_nb   = 1'b0;
    ifa.start = 1'b0; ifa.number = 16'd0;
    ifb.start = 1'b0; ifb.number = 16'd0;
    last_cnt[0] = 3'd0; last_ovf[0] = 1'b0;
    last_cnt[1] = 3'd0; last_ovf[1] = 1'b0;

    // Reset held with start asserted: reset must win.
    ifa.start = 1'b1; ifa.number = 16'd77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("A", ifa.ready, ifa.digit_valid, ifa.done, ifa.stage_number, ifa.digit_index,
                ifa.digit_count, ifa.overflow);
    check_reset("B", ifb.ready, ifb.digit_valid, ifb.done, ifb.stage_number, ifb.digit_index,
                ifb.digit_count, ifb.overflow);
    ifa.start = 1'b0;
    rst_na = 1'b1;
    rst_nb = 1'b1;
    mon_en = 1'b1;

    // 12345 with stray starts during SCAN (cycle 3) and FINISH (cycle 6).
    @(posedge clk);
    #1 ifa.start = 1'b1; ifa.number = 16'd12345;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    gen_stream(0, 16'd12345, HoldA, MaxA);
    repeat (2) @(posedge clk);
    #1 ifa.start = 1'b1; ifa.number = 16'd999;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 ifa.start = 1'b1; ifa.number = 16'd999;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    drain(0);

    conv(0, 16'd0);

    // start held high: second conversion accepted on the first ready cycle.
    @(posedge clk);
    #1 ifa.start = 1'b1; ifa.number = 16'd305;
    @(posedge clk);
    #1 ifa.number = 16'd65535;
    gen_stream(0, 16'd305, HoldA, MaxA);
    gen_stream(0, 16'd65535, HoldA, MaxA);
    repeat (ndig(305, MaxA) * HoldA + 2) @(posedge clk);
    #1 ifa.start = 1'b0;
    drain(0);

    // Reset for one cycle while digit index 2 of 12345 is presented.
    @(posedge clk);
    #1 ifa.start = 1'b1; ifa.number = 16'd12345;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    e = '{valid: 1'b1, done: 1'b0, ready: 1'b0, stage: 16'd12345, idx: 3'd0,
          cnt: last_cnt[0], ovf: last_ovf[0]};
    push(0, e);
    e.stage = 16'd1234; e.idx = 3'd1;
    push(0, e);
    e.stage = 16'd123; e.idx = 3'd2;
    push(0, e);
    e = '{valid: 1'b0, done: 1'b0, ready: 1'b1, stage: 16'd0, idx: 3'd0, cnt: 3'd0, ovf: 1'b0};
    push(0, e);
    last_cnt[0] = 3'd0;
    last_ovf[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_na = 1'b0;
    @(posedge clk);
    #1 rst_na = 1'b1;
    drain(0);
    repeat (8) @(posedge clk);

    // Hold 3, max 3 instance.
    conv(1, 16'd407);
    conv(1, 16'd65535);
    conv(1, 16'd7);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
